past_window_checker: RTL and testbench
======================================

Name: past_window_checker

Overview:
- Synthesizable hardware equivalent of the "a |-> $past(b,DEPTH) == 1" implication check.
- Sits directly downstream of the signal source under check and keeps its own DEPTH-deep history of b.
- Grades every sampled a as pass, fail or vacuous.
- Exposes per-cycle results, saturating counters and a sticky fail flag, for on-chip monitors and emulation where SVA is unavailable.

Parameters:
- DEPTH, 2, number of samples back for past_b; legal 1..16.
- CNT_W, 16, width of each event counter.
- INIT_VAL, 1'b0, value past_b returns before DEPTH samples exist (matches the SVA $past default).

Ports:
- clk  in  1  single clock, all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  sample enable; 0 freezes history, fill count and evaluation.
- clr  in  1  synchronous clear of counters and sticky_fail only; history is untouched.
- a  in  1  antecedent.
- b  in  1  signal whose history is checked.
- past_b  out  1  b from DEPTH enabled samples ago (combinational from history).
- hist_valid  out  1  high once DEPTH enabled samples have been taken since reset.
- chk_valid  out  1  registered; 1 for one cycle after each enabled sample.
- chk_pass  out  1  registered; a=1 and past_b=1 at that sample.
- chk_fail  out  1  registered; a=1 and past_b=0 at that sample.
- pass_cnt  out  CNT_W  saturating pass count.
- fail_cnt  out  CNT_W  saturating fail count.
- vac_cnt  out  CNT_W  saturating vacuous (a=0) count.
- sticky_fail  out  1  set on the first fail; held until clr or rst.

Behaviour:
- Reset:
  - history bits = INIT_VAL; fill = 0.
  - All outputs 0 except past_b = INIT_VAL.
- History:
  - Shift register hist[0..DEPTH-1].
  - On posedge with en=1: hist[0]<=b, hist[i]<=hist[i-1].
  - past_b = hist[DEPTH-1], i.e. the pre-shift value at the evaluating edge.
- Fill counter:
  - Width clog2(DEPTH+1); increments per enabled sample, saturates at DEPTH.
  - hist_valid = (fill == DEPTH).
- Evaluation: at each enabled edge, using current a and pre-shift past_b.
  - a=0: vacuous.
  - a=1 and past_b=1: pass.
  - a=1 and past_b=0: fail.
- Warm-up: during warm-up (hist_valid=0), past_b is INIT_VAL and graded normally. This mirrors SVA, so a=1 in the first DEPTH samples fails when INIT_VAL=0.
- Result timing:
  - chk_* registered, visible on the cycle after the sample edge; latency 1.
  - With en=0: chk_valid, chk_pass, chk_fail = 0; nothing else changes.
- Counters:
  - Each counter increments by 1 per matching event.
  - Holds at 2^CNT_W-1 (no wrap).
- clr:
  - Priority over a same-edge event: counters and sticky_fail go to 0 and that edge's event is not counted.
  - chk_* still reports that event.
- rst:
  - Overrides everything, including mid-warm-up or mid-run.
  - Restarts warm-up from fill=0.
- en toggling: history is indexed in enabled samples, not clock cycles.

Optional Feature:
- Macro PAST_CHK_TIMESTAMP_EN.
- Defined:
  - Adds a free-running CNT_W cycle counter (reset 0, counts every clk, wraps).
  - Adds output first_fail_ts (CNT_W), which latches the counter value at the edge where sticky_fail first sets.
  - Adds output ts_valid; first_fail_ts and ts_valid are cleared by clr or rst.
- Undefined: ports and logic absent; all other behaviour unchanged.

Decomposition:
- Package past_chk_pkg:
  - typedef enum {CHK_VAC, CHK_PASS, CHK_FAIL} chk_res_e.
  - Constants: default DEPTH, default CNT_W.
  - Function sat_inc(cnt): saturating increment.
- One sub-module, past_shift_hist:
  - DEPTH-deep enabled shift register plus fill counter.
  - Outputs past_b and hist_valid.
- Grading, counters and the optional timestamp logic stay in the top.

Test Plan:
- DEPTH=2, INIT_VAL=0, en=1.
  - rst for 1 cycle, then per-edge (a,b) = (0,0),(0,1),(1,1),(0,1),(1,1),(1,1),(0,1),(1,0),(1,0).
  - Required: fail only at the 3rd sample; pass_cnt=4, fail_cnt=1, vac_cnt=4, sticky_fail=1.
- Warm-up: INIT_VAL=1, DEPTH=3, a=1 b=0 for 3 samples, then a=1.
  - Required: first 3 samples pass with hist_valid=0; the 4th fails; hist_valid=1 from the 4th sample.
- en gating: b=1, en=0 for 5 cycles, then en=1 with b=0 for 2 samples, then a=1.
  - Required: past_b=0 (history did not advance while gated); chk_valid=0 throughout the gated cycles.
- Saturation: CNT_W=4, 20 consecutive a=0 samples.
  - Required: vac_cnt sticks at 15; then clr together with a=1 and past_b=0 gives chk_fail=1 but fail_cnt=0 and sticky_fail=0.
- Reset mid-run: after fail_cnt=3, assert rst during an a=1 sample.
  - Required: all counters 0, hist_valid=0 next cycle, no chk_valid pulse for that edge.
- PAST_CHK_TIMESTAMP_EN: first fail on cycle 7 after reset.
  - Required: first_fail_ts=7, ts_valid=1; a later fail does not change it.

Source files
------------

// File: rtl/past_chk_pkg.sv
// Shared types and helpers for past_window_checker.
package past_chk_pkg;
  typedef enum logic [1:0] {CHK_VAC, CHK_PASS, CHK_FAIL} chk_res_e;

  localparam int DEF_DEPTH = 2;
  localparam int DEF_CNT_W = 16;

  // Counter widths up to 32 are handled by widening to 32 bits.
  function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input logic [31:0] max_val);
    return (cnt == max_val) ? cnt : cnt + 32'd1;
  endfunction
endpackage

// File: rtl/past_window_checker_hist.sv
// Enabled shift-register history of b plus a saturating fill count.
module past_shift_hist
  import past_chk_pkg::*;
#(
  parameter int   DEPTH    = DEF_DEPTH,
  parameter logic INIT_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic b,
  output logic past_b,
  output logic hist_valid
);
  localparam int FW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] hist;
  logic [FW-1:0]    fill;

  always_ff @(posedge clk) begin
    if (rst) begin
      hist <= {DEPTH{INIT_VAL}};
      fill <= '0;
    end else if (en) begin
      // Shift form stays legal for DEPTH=1, where a slice would not.
      hist <= (hist << 1) | DEPTH'(b);
      if (fill != FW'(DEPTH)) fill <= fill + 1'b1;
    end
  end

  assign past_b     = hist[DEPTH-1];
  assign hist_valid = (fill == FW'(DEPTH));
endmodule

// File: rtl/past_window_checker.sv
// Hardware form of "a |-> $past(b,DEPTH)": grades each enabled sample and counts results.
// Optional first-fail timestamp is built when PAST_CHK_TIMESTAMP_EN is defined.
module past_window_checker
  import past_chk_pkg::*;
#(
  parameter int   DEPTH    = DEF_DEPTH,
  parameter int   CNT_W    = DEF_CNT_W,
  parameter logic INIT_VAL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             a,
  input  logic             b,
  output logic             past_b,
  output logic             hist_valid,
  output logic             chk_valid,
  output logic             chk_pass,
  output logic             chk_fail,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [CNT_W-1:0] vac_cnt,
`ifdef PAST_CHK_TIMESTAMP_EN
  output logic [CNT_W-1:0] first_fail_ts,
  output logic             ts_valid,
`endif
  output logic             sticky_fail
);
  localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

  chk_res_e res;

  past_shift_hist #(.DEPTH(DEPTH), .INIT_VAL(INIT_VAL)) u_hist (
    .clk(clk), .rst(rst), .en(en), .b(b),
    .past_b(past_b), .hist_valid(hist_valid)
  );

  // past_b is still the pre-shift value here, which is what gets graded.
  always_comb begin
    res = CHK_VAC;
    if (a) res = past_b ? CHK_PASS : CHK_FAIL;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      chk_valid   <= 1'b0;
      chk_pass    <= 1'b0;
      chk_fail    <= 1'b0;
      pass_cnt    <= '0;
      fail_cnt    <= '0;
      vac_cnt     <= '0;
      sticky_fail <= 1'b0;
    end else begin
      chk_valid <= en;
      chk_pass  <= en && (res == CHK_PASS);
      chk_fail  <= en && (res == CHK_FAIL);
      if (clr) begin
        pass_cnt    <= '0;
        fail_cnt    <= '0;
        vac_cnt     <= '0;
        sticky_fail <= 1'b0;
      end else if (en) begin
        case (res)
          CHK_PASS: pass_cnt <= CNT_W'(sat_inc(32'(pass_cnt), CNT_MAX));
          CHK_FAIL: begin
            fail_cnt    <= CNT_W'(sat_inc(32'(fail_cnt), CNT_MAX));
            sticky_fail <= 1'b1;
          end
          default:  vac_cnt  <= CNT_W'(sat_inc(32'(vac_cnt), CNT_MAX));
        endcase
      end
    end
  end

`ifdef PAST_CHK_TIMESTAMP_EN
  logic [CNT_W-1:0] cyc_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_cnt       <= '0;
      first_fail_ts <= '0;
      ts_valid      <= 1'b0;
    end else begin
      cyc_cnt <= cyc_cnt + 1'b1;
      if (clr) begin
        first_fail_ts <= '0;
        ts_valid      <= 1'b0;
      end else if (en && (res == CHK_FAIL) && !sticky_fail) begin
        first_fail_ts <= cyc_cnt;
        ts_valid      <= 1'b1;
      end
    end
  end
`endif
endmodule

// File: tb/tb_past_window_checker.sv
// Randomized + directed bench for past_window_checker with a queue-based reference model.
module tb_past_window_checker;
  localparam int   D    = 3;
  localparam int   CW   = 4;
  localparam logic INIT = 1'b1;
  localparam int   MAXC = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1, en = 1'b0, clr = 1'b0, a = 1'b0, b = 1'b0;
  logic past_b, hist_valid, chk_valid, chk_pass, chk_fail, sticky_fail;
  logic [CW-1:0] pass_cnt, fail_cnt, vac_cnt;
`ifdef PAST_CHK_TIMESTAMP_EN
  logic [CW-1:0] first_fail_ts;
  logic          ts_valid;
`endif

  always #5 clk = ~clk;

  past_window_checker #(.DEPTH(D), .CNT_W(CW), .INIT_VAL(INIT)) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .a(a), .b(b),
    .past_b(past_b), .hist_valid(hist_valid),
    .chk_valid(chk_valid), .chk_pass(chk_pass), .chk_fail(chk_fail),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .vac_cnt(vac_cnt),
`ifdef PAST_CHK_TIMESTAMP_EN
    .first_fail_ts(first_fail_ts), .ts_valid(ts_valid),
`endif
    .sticky_fail(sticky_fail)
  );

  typedef struct {
    int cv, cp, cf, pc, fc, vc, st, hv, pb, ts, tv;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0, bad = 0;

  // Reference model: raw queue of enabled b samples and integer counters.
  bit bq[$];
  int m_pc, m_fc, m_vc, m_st, m_tsc, m_ts, m_tv;

  task automatic chk(input string nm, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d t=%0t", nm, act, expv, $time);
    end
  endtask

  function automatic int model_past();
    return (bq.size() < D) ? int'(INIT) : int'(bq[0]);
  endfunction

  task automatic step(input bit r, input bit e, input bit c, input bit ai, input bit bi);
    exp_t x;
    int   pb;
    @(negedge clk);
    rst = r; en = e; clr = c; a = ai; b = bi;
    @(posedge clk);
    x = '{default: 0};
    if (r) begin
      bq.delete();
      m_pc = 0; m_fc = 0; m_vc = 0; m_st = 0; m_tsc = 0; m_ts = 0; m_tv = 0;
    end else begin
      pb = model_past();
      if (e) begin
        x.cv = 1;
        x.cp = (ai && pb == 1) ? 1 : 0;
        x.cf = (ai && pb == 0) ? 1 : 0;
        bq.push_back(bi);
        if (bq.size() > D) void'(bq.pop_front());
      end
      if (c) begin
        m_pc = 0; m_fc = 0; m_vc = 0; m_st = 0; m_ts = 0; m_tv = 0;
      end else if (e) begin
        if (x.cp == 1)      m_pc = (m_pc < MAXC) ? m_pc + 1 : MAXC;
        else if (x.cf == 1) m_fc = (m_fc < MAXC) ? m_fc + 1 : MAXC;
        else                m_vc = (m_vc < MAXC) ? m_vc + 1 : MAXC;
        if (x.cf == 1 && m_st == 0) begin
          m_ts = m_tsc; m_tv = 1;
        end
        if (x.cf == 1) m_st = 1;
      end
      m_tsc = (m_tsc + 1) % (MAXC + 1);
    end
    x.pc = m_pc; x.fc = m_fc; x.vc = m_vc; x.st = m_st;
    x.hv = (bq.size() >= D) ? 1 : 0;
    x.pb = model_past();
    x.ts = m_ts; x.tv = m_tv;
    exp_q.push_back(x);
  endtask

  // Monitor: one expected record per edge; chk_valid must agree with it.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("chk_valid", int'(chk_valid), e.cv);
      if (chk_valid) begin
        chk("chk_pass", int'(chk_pass), e.cp);
        chk("chk_fail", int'(chk_fail), e.cf);
      end
      chk("pass_cnt", int'(pass_cnt), e.pc);
      chk("fail_cnt", int'(fail_cnt), e.fc);
      chk("vac_cnt", int'(vac_cnt), e.vc);
      chk("sticky_fail", int'(sticky_fail), e.st);
      chk("hist_valid", int'(hist_valid), e.hv);
      chk("past_b", int'(past_b), e.pb);
`ifdef PAST_CHK_TIMESTAMP_EN
      chk("first_fail_ts", int'(first_fail_ts), e.ts);
      chk("ts_valid", int'(ts_valid), e.tv);
`endif
    end
  end

  typedef struct { bit a, b; } ab_t;
  ab_t seq1[9] = '{'{0,0}, '{0,1}, '{1,1}, '{0,1}, '{1,1}, '{1,1}, '{0,1}, '{1,0}, '{1,0}};

  initial begin
    // Reset and basic pattern sequence
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    foreach (seq1[i]) step(0, 1, 0, seq1[i].a, seq1[i].b);

    // Warm-up with INIT_VAL=1: three passes, then a fail on real history
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 1, 0);
    step(0, 1, 0, 1, 0);
    step(0, 1, 0, 1, 1);

    // en gating: history must not advance while disabled
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 1);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 1, 0);

    // Saturation of vac_cnt, then clr on a failing sample
    step(0, 1, 1, 0, 0);
    for (int i = 0; i < 20; i++) step(0, 1, 0, 0, 0);
    step(0, 1, 1, 1, 0);
    step(0, 0, 0, 0, 0);

    // Build up fails, then reset during an a=1 sample
    for (int i = 0; i < 4; i++) step(0, 1, 0, 1, 0);
    step(1, 1, 0, 1, 0);
    step(0, 0, 0, 0, 0);

    // Timestamp scenario: first fail at cycle counter 7, later fail ignored
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 1, 0);
    step(0, 1, 0, 1, 0);
    step(0, 1, 0, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 1, 0);

    // Randomized traffic
    for (int i = 0; i < 600; i++)
      step($urandom_range(99) < 2, $urandom_range(99) < 80, $urandom_range(99) < 4,
           1'($urandom_range(1)), 1'($urandom_range(1)));

    step(0, 0, 0, 0, 0);
    @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
